mod_word_accum: RTL and testbench
=================================

Name: mod_word_accum

Overview:
- Downstream consumer of the registered 32-bit AND stage.
- Takes that stage's word output (data_in) and its 1-bit output as a qualifier (valid_in). Sums consecutive valid words into blocks of BLOCK_LEN words.
- Presents each block sum on a valid/ready output register.
- The upstream stage has no backpressure, so input is never stalled. A completed sum that is not consumed in time is overwritten, and a sticky overrun flag is set.

Parameters:
- BITS, 32, data word width; matches upstream operand width.
- BLOCK_LEN, 4, valid words per block; legal range 1..2^CNT_BITS.
- CNT_BITS, 2, word-counter width; 2^CNT_BITS >= BLOCK_LEN.
- SUM_BITS, 34, sum width; must equal BITS+CNT_BITS so a full block cannot overflow.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  BITS  word from upstream stage.
- valid_in  input  1  data_in qualifier; word consumed on every clock edge where it is high.
- clear  input  1  synchronous flush of the partial block and the overrun flag.
- sum_out  output  SUM_BITS  completed block sum.
- sum_valid  output  1  sum_out holds an unconsumed sum.
- sum_ready  input  1  downstream accepts sum_out when high together with sum_valid.
- overrun  output  1  sticky: an unconsumed sum was overwritten.
- block_cnt  output  8  completed blocks, modulo 256.

Behaviour:
- Reset (asynchronous, active-high): all outputs and internal state go to 0.
  - sum_out=0, sum_valid=0, overrun=0, block_cnt=0, acc=0, cnt=0, state=IDLE.
  - Reset mid-block discards the partial sum; no output pulse.
- FSM states: IDLE (no words held), ACCUM (1..BLOCK_LEN-1 words held).
- IDLE with valid_in=1:
  - acc<=data_in zero-extended to SUM_BITS; cnt<=1; go to ACCUM.
  - If BLOCK_LEN==1, this is a completion instead and the state stays IDLE.
- ACCUM with valid_in=1 and cnt<BLOCK_LEN-1: acc<=acc+data_in; cnt<=cnt+1.
- ACCUM with valid_in=1 and cnt==BLOCK_LEN-1: completion.
  - sum_out<=acc+data_in; acc<=0; cnt<=0; go to IDLE.
- valid_in=0: acc, cnt and state hold. Gaps between valid words are allowed and do not break a block.
- Completion side effects, all on the same edge:
  - sum_valid<=1.
  - block_cnt<=block_cnt+1, wrapping 255 to 0.
- Latency: sum_valid and sum_out are visible in the cycle after the edge that samples the final word.
- Output handshake:
  - A transfer occurs on an edge where sum_valid=1 and sum_ready=1.
  - Transfer without completion: sum_valid<=0.
  - Transfer and completion on the same edge: the new sum loads, sum_valid stays 1, overrun is unchanged.
  - Completion with sum_valid=1 and sum_ready=0: sum_out is overwritten and overrun<=1.
  - sum_out is stable while sum_valid=1 and no completion occurs.
- overrun stays 1 until reset or clear.
- clear=1:
  - acc<=0, cnt<=0, state<=IDLE, overrun<=0.
  - Takes precedence over valid_in on the same edge; that word is discarded and no completion occurs.
  - sum_out, sum_valid and block_cnt are not affected by clear. The handshake still operates during clear.
- Arithmetic: unsigned, SUM_BITS wide, no saturation. Full-scale blocks fit exactly: BLOCK_LEN*(2^BITS-1) < 2^SUM_BITS.

Decomposition:
- Shared package/include:
  - BITS define, reused from the upstream stage's operand-width define so both stages agree.
  - FSM state encodings IDLE=1'b0, ACCUM=1'b1.
  - Default BLOCK_LEN and CNT_BITS.
- Sub-module, natural and single: mod_sum_outreg.
  - Owns sum_out, sum_valid and overrun.
  - Inputs: load pulse, load value, sum_ready, clear.
- The accumulator, counter and FSM stay in the top module.

Test Plan:
1. Reset, then valid words 1,2,3,4 on consecutive cycles with sum_ready=1 -> one cycle after the 4th word: sum_out=10, sum_valid=1 for exactly one cycle, block_cnt=1.
2. Words 0xFFFFFFFF x4 with valid_in gaps of 0-3 idle cycles between them -> sum_out=0x3FFFFFFFC, no early completion, overrun=0.
3. sum_ready=0; two blocks {1,1,1,1} then {2,2,2,2} -> sum_out=4 then overwritten to 8; overrun=1 and remains 1 after sum_ready rises; block_cnt=2.
4. Handshake and completion on the same edge: block {1,1,1,1} completes, then sum_ready=1 exactly on the edge completing block {5,5,5,5} -> sum_valid stays 1, sum_out=20, overrun=0.
5. Words 7,7 then clear together with a valid 7, then 1,1,1,1 -> sum_out=4; block_cnt increments once; a clear while overrun=1 drops overrun to 0.
6. Reset asserted asynchronously mid-cycle after 3 of 4 words -> all outputs 0 immediately without waiting for a clock edge; the next 4 words {2,2,2,2} give sum_out=8. Also run 256 blocks -> block_cnt wraps to 0.

Source files
------------

// File: rtl/mod_word_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mod_word_accum_pkg
//  Brief    : Shared widths, defaults and FSM encodings for the word accumulator.
//  Revision : 1.0 - initial release
// ============================================================================

// Operand width shared with the upstream AND stage so both stages agree.
`ifndef AND_STAGE_BITS
`define AND_STAGE_BITS 32
`endif

package mod_word_accum_pkg;

    localparam int c_default_bits      = `AND_STAGE_BITS;
    localparam int c_default_block_len = 4;
    localparam int c_default_cnt_bits  = 2;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_accum = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mod_sum_outreg.sv
`default_nettype none
// ============================================================================
//  Module   : mod_sum_outreg
//  Brief    : Valid/ready output register for block sums with sticky overrun.
//  Revision : 1.0 - initial release
// ============================================================================

module mod_sum_outreg #(
    parameter int SUM_BITS = 34
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [SUM_BITS-1:0] load_value,
    input  logic                sum_ready,
    input  logic                clear,
    output logic [SUM_BITS-1:0] sum_out,
    output logic                sum_valid,
    output logic                overrun
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_out   <= '0;
            sum_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A new sum always wins; a simultaneous transfer simply keeps valid high.
            if (load) begin
                sum_out   <= load_value;
                sum_valid <= 1'b1;
            end else if (sum_valid && sum_ready) begin
                sum_valid <= 1'b0;
            end

            if (clear) begin
                overrun <= 1'b0;
            end else if (load && sum_valid && !sum_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mod_word_accum.sv
`default_nettype none
// ============================================================================
//  Module   : mod_word_accum
//  Brief    : Sums blocks of BLOCK_LEN valid words and presents each block sum.
//  Revision : 1.0 - initial release
// ============================================================================

module mod_word_accum
    import mod_word_accum_pkg::*;
#(
    parameter int BITS      = c_default_bits,
    parameter int BLOCK_LEN = c_default_block_len,
    parameter int CNT_BITS  = c_default_cnt_bits,
    parameter int SUM_BITS  = BITS + CNT_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [BITS-1:0]     data_in,
    input  logic                valid_in,
    input  logic                clear,
    output logic [SUM_BITS-1:0] sum_out,
    output logic                sum_valid,
    input  logic                sum_ready,
    output logic                overrun,
    output logic [7:0]          block_cnt
);

    localparam logic [CNT_BITS-1:0] c_last_cnt = CNT_BITS'(BLOCK_LEN - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [SUM_BITS-1:0] r_acc;
    logic [SUM_BITS-1:0] w_acc_nxt;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic [SUM_BITS-1:0] w_data_ext;
    logic [SUM_BITS-1:0] w_sum;
    logic                w_last;
    logic                w_load;

    assign w_data_ext = SUM_BITS'(data_in);
    assign w_sum      = r_acc + w_data_ext;
    // cnt is 0 in IDLE, so a one-word block completes straight from IDLE.
    assign w_last     = (r_cnt == c_last_cnt);

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        if (clear) begin
            w_state_nxt = c_st_idle;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
        end else if (valid_in) begin
            if (w_last) begin
                w_load      = 1'b1;
                w_state_nxt = c_st_idle;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
            end else if (r_state == c_st_idle) begin
                w_state_nxt = c_st_accum;
                w_acc_nxt   = w_data_ext;
                w_cnt_nxt   = CNT_BITS'(1);
            end else begin
                w_acc_nxt   = w_sum;
                w_cnt_nxt   = r_cnt + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_acc     <= '0;
            r_cnt     <= '0;
            block_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                block_cnt <= block_cnt + 8'd1;
            end
        end
    end

    mod_sum_outreg #(
        .SUM_BITS (SUM_BITS)
    ) u_outreg (
        .clock      (clock),
        .reset      (reset),
        .load       (w_load),
        .load_value (w_sum),
        .sum_ready  (sum_ready),
        .clear      (clear),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .overrun    (overrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_mod_word_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_word_accum
//  Brief    : Self-checking bench for mod_word_accum (vectors, corners, random).
//  Revision : 1.0 - initial release
// ============================================================================

module tb_mod_word_accum;

    localparam int c_block_len = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        clear = 1'b0;
    logic [33:0] sum_out;
    logic        sum_valid;
    logic        sum_ready = 1'b0;
    logic        overrun;
    logic [7:0]  block_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: words of the open block, plus the visible output state.
    logic [31:0] m_words[$];
    logic [33:0] m_sum;
    logic        m_valid;
    logic        m_ovr;
    logic [7:0]  m_blk;

    always #5 clock = ~clock;

    mod_word_accum dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .clear     (clear),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .overrun   (overrun),
        .block_cnt (block_cnt)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        c;
        logic        r;
        logic [33:0] e_sum;
        logic        e_valid;
        logic        e_ovr;
        logic [7:0]  e_blk;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_sum   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_blk   = 8'd0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic c, input logic r);
        longint s;
        logic   done;
        done = 1'b0;
        s    = 0;
        if (c) begin
            m_words.delete();
            m_ovr = 1'b0;
        end else if (v) begin
            m_words.push_back(d);
            if (m_words.size() == c_block_len) begin
                foreach (m_words[i]) s += longint'(m_words[i]);
                m_words.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (m_valid && !r) m_ovr = 1'b1;
            m_sum   = s[33:0];
            m_valid = 1'b1;
            m_blk   = m_blk + 8'd1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, return at next falling edge.
    task automatic step(input logic v, input logic [31:0] d, input logic c, input logic r);
        valid_in  = v;
        data_in   = d;
        clear     = c;
        sum_ready = r;
        @(posedge clock);
        model_edge(v, d, c, r);
        @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sum_out"},   64'(sum_out),   64'(m_sum));
        chk({tag, ".sum_valid"}, 64'(sum_valid), 64'(m_valid));
        chk({tag, ".overrun"},   64'(overrun),   64'(m_ovr));
        chk({tag, ".block_cnt"}, 64'(block_cnt), 64'(m_blk));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        clear    = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    vec_t vt[15];

    initial begin
        logic [7:0] blk0;

        // Test 1 then test 3 back to back: one normal block, then two overwritten blocks.
        vt[0]  = '{1'b1, 32'd1, 1'b0, 1'b1, 34'd0,  1'b0, 1'b0, 8'd0};
        vt[1]  = '{1'b1, 32'd2, 1'b0, 1'b1, 34'd0,  1'b0, 1'b0, 8'd0};
        vt[2]  = '{1'b1, 32'd3, 1'b0, 1'b1, 34'd0,  1'b0, 1'b0, 8'd0};
        vt[3]  = '{1'b1, 32'd4, 1'b0, 1'b1, 34'd10, 1'b1, 1'b0, 8'd1};
        vt[4]  = '{1'b0, 32'd0, 1'b0, 1'b1, 34'd10, 1'b0, 1'b0, 8'd1};
        vt[5]  = '{1'b1, 32'd1, 1'b0, 1'b0, 34'd10, 1'b0, 1'b0, 8'd1};
        vt[6]  = '{1'b1, 32'd1, 1'b0, 1'b0, 34'd10, 1'b0, 1'b0, 8'd1};
        vt[7]  = '{1'b1, 32'd1, 1'b0, 1'b0, 34'd10, 1'b0, 1'b0, 8'd1};
        vt[8]  = '{1'b1, 32'd1, 1'b0, 1'b0, 34'd4,  1'b1, 1'b0, 8'd2};
        vt[9]  = '{1'b1, 32'd2, 1'b0, 1'b0, 34'd4,  1'b1, 1'b0, 8'd2};
        vt[10] = '{1'b1, 32'd2, 1'b0, 1'b0, 34'd4,  1'b1, 1'b0, 8'd2};
        vt[11] = '{1'b1, 32'd2, 1'b0, 1'b0, 34'd4,  1'b1, 1'b0, 8'd2};
        vt[12] = '{1'b1, 32'd2, 1'b0, 1'b0, 34'd8,  1'b1, 1'b1, 8'd3};
        vt[13] = '{1'b0, 32'd0, 1'b0, 1'b1, 34'd8,  1'b0, 1'b1, 8'd3};
        vt[14] = '{1'b0, 32'd0, 1'b0, 1'b1, 34'd8,  1'b0, 1'b1, 8'd3};

        model_reset();
        @(negedge clock);
        chk("rst.sum_out",   64'(sum_out),   64'd0);
        chk("rst.sum_valid", 64'(sum_valid), 64'd0);
        chk("rst.overrun",   64'(overrun),   64'd0);
        chk("rst.block_cnt", 64'(block_cnt), 64'd0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            step(vt[i].v, vt[i].d, vt[i].c, vt[i].r);
            chk($sformatf("vec%0d.sum_out", i),   64'(sum_out),   64'(vt[i].e_sum));
            chk($sformatf("vec%0d.sum_valid", i), 64'(sum_valid), 64'(vt[i].e_valid));
            chk($sformatf("vec%0d.overrun", i),   64'(overrun),   64'(vt[i].e_ovr));
            chk($sformatf("vec%0d.block_cnt", i), 64'(block_cnt), 64'(vt[i].e_blk));
        end

        // Full-scale words with growing idle gaps.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
            check_model("gap");
            for (int g = 0; g < i; g++) begin
                step(1'b0, 32'h0, 1'b0, 1'b1);
                check_model("gap.idle");
            end
            if (i == 2) chk("gap.no_early", 64'(sum_valid), 64'd0);
        end
        chk("gap.sum_full", 64'(sum_out), 64'h3_FFFF_FFFC);
        chk("gap.ovr",      64'(overrun), 64'd0);

        // Transfer and completion on the same edge.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd5, 1'b0, 1'b0);
        step(1'b1, 32'd5, 1'b0, 1'b1);
        chk("same.sum_valid", 64'(sum_valid), 64'd1);
        chk("same.sum_out",   64'(sum_out),   64'd20);
        chk("same.overrun",   64'(overrun),   64'd0);
        check_model("same");

        // Clear discards the partial block and the word presented with it.
        do_reset();
        step(1'b1, 32'd7, 1'b0, 1'b1);
        step(1'b1, 32'd7, 1'b0, 1'b1);
        step(1'b1, 32'd7, 1'b1, 1'b1);
        check_model("clr.flush");
        blk0 = block_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 32'd1, 1'b0, 1'b1);
        chk("clr.sum_out",   64'(sum_out),   64'd4);
        chk("clr.blk_delta", 64'(block_cnt - blk0), 64'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 32'd3, 1'b0, 1'b0);
        chk("clr.ovr_set", 64'(overrun), 64'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("clr.ovr_drop", 64'(overrun), 64'd0);
        chk("clr.valid_kept", 64'(sum_valid), 64'd1);
        check_model("clr.end");

        // Asynchronous reset between clock edges after 3 of 4 words.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'd9, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd9, 1'b0, 1'b0);
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst.sum_out",   64'(sum_out),   64'd0);
        chk("arst.sum_valid", 64'(sum_valid), 64'd0);
        chk("arst.overrun",   64'(overrun),   64'd0);
        chk("arst.block_cnt", 64'(block_cnt), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'd2, 1'b0, 1'b1);
        chk("arst.sum_after", 64'(sum_out), 64'd8);
        check_model("arst");

        // 256 blocks wrap the block counter.
        do_reset();
        for (int b = 0; b < 256; b++)
            for (int i = 0; i < 4; i++) step(1'b1, 32'(b + i), 1'b0, 1'b1);
        chk("wrap.block_cnt", 64'(block_cnt), 64'd0);
        check_model("wrap");

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            step(1'($urandom_range(0, 3) != 0), d,
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
